sad_accumulator: RTL

Control and datapath stage directly downstream of the 9-bit pixel index counter in the SAD engine. It drives the counter's enable and synchronous clear, and uses the counter's index `i` as the read address into the two pixel block memories (reference block A, candidate block B). It forms |A−B| per pixel and accumulates the sum over `N_PIX` pixels. When the sum is complete, it presents the final SAD with a one-cycle valid pulse.

---
 rtl/sad_pkg.sv | 17 +
 rtl/sad_absdiff.sv | 15 +
 rtl/sad_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sad_pkg.sv
// Shared types and default sizing for the SAD engine (accumulator, counter, memory wrappers).
package sad_pkg;

  localparam int unsigned N_PIX = 256;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned SAD_W = 16;
  localparam int unsigned IDX_W = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sad_state_e;

endpackage : sad_pkg

// File: rtl/sad_absdiff.sv
// Combinational absolute difference of two unsigned pixels; the parent registers the result.
module sad_absdiff #(
  parameter int unsigned PIX_W = sad_pkg::PIX_W
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] abs_c
);

  // Compare first so the subtraction never wraps.
  always_comb begin
    abs_c = (a >= b) ? (a - b) : (b - a);
  end

endmodule : sad_absdiff

// File: rtl/sad_accumulator.sv
// SAD control and datapath: sequences the pixel index counter, reads both blocks,
// accumulates |A-B| over N_PIX pixels and publishes the sum with a one-cycle valid.
module sad_accumulator #(
  parameter int unsigned N_PIX = sad_pkg::N_PIX,
  parameter int unsigned PIX_W = sad_pkg::PIX_W,
  parameter int unsigned SAD_W = sad_pkg::SAD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic [sad_pkg::IDX_W-1:0] i,
  output logic                     cnt_en,
  output logic                     cnt_clr,
  output logic [sad_pkg::IDX_W-1:0] addr,
  input  logic [PIX_W-1:0]         a_data,
  input  logic [PIX_W-1:0]         b_data,
  output logic                     busy,
  output logic [SAD_W-1:0]         sad_out,
  output logic                     sad_valid
);

  import sad_pkg::*;

  sad_state_e       state_q, state_d;
  logic             drain_q, drain_d;
  logic             rd_v;
  logic             rd_v_d1_q, rd_v_d1_d;
  logic             diff_v_q, diff_v_d;
  logic [PIX_W-1:0] diff_q, diff_d;
  logic [PIX_W-1:0] abs_c;
  logic [SAD_W-1:0] acc_q, acc_d;
  logic [SAD_W-1:0] sad_out_q, sad_out_d;
  logic             sad_valid_q, sad_valid_d;
  logic             busy_q, busy_d;
  logic             last_idx;

  // Final read of the block is issued when the counter reaches N_PIX-1.
  assign last_idx = (i == IDX_W'(N_PIX - 1));
  assign addr     = i;

  sad_absdiff #(.PIX_W(PIX_W)) u_absdiff (
    .a     (a_data),
    .b     (b_data),
    .abs_c (abs_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; go outside IDLE is dropped, never queued.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = CLR;
      CLR:     state_d = RUN;
      RUN:     if (last_idx) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs to the counter and the read-valid for the pipeline.
  always_comb begin
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    rd_v    = 1'b0;
    unique case (state_q)
      CLR: cnt_clr = 1'b1;
      RUN: begin
        rd_v   = 1'b1;
        cnt_en = !last_idx;
      end
      default: ;
    endcase
  end

  // Datapath next values: read-valid pipeline, diff stage, accumulator, result.
  always_comb begin
    drain_d     = (state_q == DRAIN) ? ~drain_q : 1'b0;
    rd_v_d1_d   = rd_v;
    diff_v_d    = rd_v_d1_q;
    diff_d      = rd_v_d1_q ? abs_c : diff_q;
    acc_d       = diff_v_q ? (acc_q + SAD_W'(diff_q)) : acc_q;
    sad_valid_d = (state_q == DONE);
    sad_out_d   = (state_q == DONE) ? acc_q : sad_out_q;
    busy_d      = (state_d != IDLE);
    if (state_q == CLR) begin
      rd_v_d1_d = 1'b0;
      diff_v_d  = 1'b0;
      acc_d     = '0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_q     <= 1'b0;
      rd_v_d1_q   <= 1'b0;
      diff_v_q    <= 1'b0;
      diff_q      <= '0;
      acc_q       <= '0;
      sad_out_q   <= '0;
      sad_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      drain_q     <= drain_d;
      rd_v_d1_q   <= rd_v_d1_d;
      diff_v_q    <= diff_v_d;
      diff_q      <= diff_d;
      acc_q       <= acc_d;
      sad_out_q   <= sad_out_d;
      sad_valid_q <= sad_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sad_out   = sad_out_q;
  assign sad_valid = sad_valid_q;
  assign busy      = busy_q;

endmodule : sad_accumulator
